// File: rtl/ofs_pkg.sv
// Shared types and widths for the operand fetch stage: the FSM state enum
// and a saturating increment for the bubble counter.
package ofs_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int CNT_W      = 16;

  typedef enum logic {
    OFS_RUN    = 1'b0,
    OFS_BUBBLE = 1'b1
  } ofsState_t;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Output handshake from the operand fetch stage to EX: resolved operands plus
// the destination that travels with them.
interface operand_fetch_stage_if #(
  parameter int DATA_W     = ofs_pkg::DATA_W,
  parameter int REG_ADDR_W = ofs_pkg::REG_ADDR_W
);
  // A transfer happens on a rising edge where out_valid && out_ready. Once
  // out_valid is high the payload stays stable until that transfer.
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_op1;
  logic [DATA_W-1:0]     out_op2;
  logic [REG_ADDR_W-1:0] out_dst;
  logic                  out_dst_wr;

  modport master (
    output out_valid, out_op1, out_op2, out_dst, out_dst_wr,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_op1, out_op2, out_dst, out_dst_wr,
    output out_ready
  );
endinterface

// File: rtl/operand_fetch_stage_fwd_mux.sv
// Forwarding select for one source operand: EX ALU result beats MEM result,
// which beats the register file word. Unused sources pass rf_data through.
module fwd_mux #(
  parameter int DATA_W     = ofs_pkg::DATA_W,
  parameter int REG_ADDR_W = ofs_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  used,
  input  logic [DATA_W-1:0]     rf_data,
  input  logic                  ex_wr,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic [DATA_W-1:0]     ex_result,
  input  logic                  mem_wr,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  input  logic [DATA_W-1:0]     mem_result,
  output logic [DATA_W-1:0]     resolved
);

  // A load in EX has no data yet; that case is covered by the bubble instead.
  always_comb begin
    resolved = rf_data;
    if (used) begin
      if (ex_wr && !ex_is_load && (ex_dst == src)) begin
        resolved = ex_result;
      end else if (mem_wr && (mem_dst == src)) begin
        resolved = mem_result;
      end
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: forwards EX/MEM results into the register file
// operands, stalls one bubble on load-use, and holds one entry for EX.
module operand_fetch_stage #(
  parameter int DATA_W     = ofs_pkg::DATA_W,
  parameter int REG_ADDR_W = ofs_pkg::REG_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [REG_ADDR_W-1:0]  src1_id,
  input  logic [REG_ADDR_W-1:0]  src2_id,
  input  logic                   src1_used,
  input  logic                   src2_used,
  input  logic [REG_ADDR_W-1:0]  dst_id,
  input  logic                   dst_wr,
  input  logic [DATA_W-1:0]      rf_data_1,
  input  logic [DATA_W-1:0]      rf_data_2,
  input  logic                   ex_wr,
  input  logic                   ex_is_load,
  input  logic [REG_ADDR_W-1:0]  ex_dst,
  input  logic [DATA_W-1:0]      ex_result,
  input  logic                   mem_wr,
  input  logic [REG_ADDR_W-1:0]  mem_dst,
  input  logic [DATA_W-1:0]      mem_result,
  input  logic                   flush,
  operand_fetch_stage_if.master  exPort,
  output logic [15:0]            bubble_cnt,
  output ofs_pkg::ofsState_t     dbgState
);
  import ofs_pkg::*;

  ofsState_t             state;
  logic                  outValid;
  logic [DATA_W-1:0]     op1Q, op2Q;
  logic [REG_ADDR_W-1:0] dstQ;
  logic                  dstWrQ;
  logic [CNT_W-1:0]      bubbleCnt;

  logic                  free, haz, accept;
  logic [DATA_W-1:0]     op1Fwd, op2Fwd;

  fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd1 (
    .src(src1_id), .used(src1_used), .rf_data(rf_data_1),
    .ex_wr(ex_wr), .ex_is_load(ex_is_load), .ex_dst(ex_dst), .ex_result(ex_result),
    .mem_wr(mem_wr), .mem_dst(mem_dst), .mem_result(mem_result),
    .resolved(op1Fwd)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd2 (
    .src(src2_id), .used(src2_used), .rf_data(rf_data_2),
    .ex_wr(ex_wr), .ex_is_load(ex_is_load), .ex_dst(ex_dst), .ex_result(ex_result),
    .mem_wr(mem_wr), .mem_dst(mem_dst), .mem_result(mem_result),
    .resolved(op2Fwd)
  );

  assign free = !outValid || exPort.out_ready;
  assign haz  = in_valid && ex_wr && ex_is_load &&
                ((src1_used && (ex_dst == src1_id)) ||
                 (src2_used && (ex_dst == src2_id)));

  // Gated by rst so upstream never sees a handshake while reset is held.
  assign in_ready = rst && (state == OFS_RUN) && free && !haz && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= OFS_RUN;
      outValid  <= 1'b0;
      op1Q      <= '0;
      op2Q      <= '0;
      dstQ      <= '0;
      dstWrQ    <= 1'b0;
      bubbleCnt <= '0;
    end else if (flush) begin
      state    <= OFS_RUN;
      outValid <= 1'b0;
    end else begin
      case (state)
        OFS_RUN: begin
          if (free) begin
            if (accept) begin
              outValid <= 1'b1;
              op1Q     <= op1Fwd;
              op2Q     <= op2Fwd;
              dstQ     <= dst_id;
              dstWrQ   <= dst_wr;
            end else if (haz) begin
              outValid  <= 1'b0;
              bubbleCnt <= satInc(bubbleCnt);
              state     <= OFS_BUBBLE;
            end else begin
              outValid <= 1'b0;
            end
          end
        end
        // The load moves into MEM during this cycle and is forwarded from there.
        OFS_BUBBLE: begin
          outValid <= 1'b0;
          state    <= OFS_RUN;
        end
        default: state <= OFS_RUN;
      endcase
    end
  end

  assign exPort.out_valid  = outValid;
  assign exPort.out_op1    = op1Q;
  assign exPort.out_op2    = op2Q;
  assign exPort.out_dst    = dstQ;
  assign exPort.out_dst_wr = dstWrQ;
  assign bubble_cnt        = bubbleCnt;
  assign dbgState          = state;

endmodule
